// File: rtl/rod_kick_scheduler.sv
// Kick sequencer for one foosball rod: a held key winds the rod on a slow tick, and releasing
// it fires a one-cycle kick. The rod then recovers to neutral and sits out a cooldown.
module rod_kick_scheduler #(
    parameter int unsigned TICK_DIV       = 2_500_000,
    parameter int unsigned MAX_STEP       = 7,
    parameter int unsigned COOLDOWN_TICKS = 10
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              turbo,
    input  logic              key6Pressed,
    input  logic              key4Pressed,
    output logic signed [3:0] angle,
    output logic              kick_pulse,
    output logic              kick_dir,
    output logic [2:0]        kick_strength,
    output logic              busy
);

    localparam int unsigned CW  = $clog2(TICK_DIV + 1);
    localparam int unsigned CDW = $clog2(COOLDOWN_TICKS + 1);

    localparam logic [CW-1:0]     LIM_NORM  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]     LIM_TURBO = CW'(TICK_DIV / 10 - 1);
    localparam logic [CDW-1:0]    CD_LAST   = CDW'(COOLDOWN_TICKS - 1);
    localparam logic signed [3:0] MAX_POS   = 4'(MAX_STEP);
    localparam logic signed [3:0] MAX_NEG   = -MAX_POS;

    typedef enum logic [2:0] {IDLE, WIND6, WIND4, STRIKE, RECOVER, COOLDOWN} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [CDW-1:0]    r_cd;
    logic              r_armed;
    logic signed [3:0] r_angle;
    logic              r_kick_pulse;
    logic              r_kick_dir;
    logic [2:0]        r_kick_strength;

    logic [CW-1:0]     w_limit;
    logic              w_tick;
    logic [3:0]        w_abs;

    // >= rather than == so a turbo switch past the new limit still ticks next cycle
    assign w_limit = turbo ? LIM_TURBO : LIM_NORM;
    assign w_tick  = (r_state != IDLE) && (r_cnt >= w_limit);
    assign w_abs   = r_angle[3] ? -r_angle : r_angle;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_cd            <= '0;
            r_armed         <= 1'b1;
            r_angle         <= '0;
            r_kick_pulse    <= 1'b0;
            r_kick_dir      <= 1'b0;
            r_kick_strength <= '0;
        end else begin
            r_kick_pulse <= 1'b0;
            r_cnt        <= w_tick ? '0 : r_cnt + 1'b1;
            unique case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_angle <= '0;
                    if (!key6Pressed && !key4Pressed) r_armed <= 1'b1;
                    if (r_armed && key6Pressed && !key4Pressed) begin
                        r_state <= WIND6;
                    end else if (r_armed && key4Pressed && !key6Pressed) begin
                        r_state <= WIND4;
                    end
                end
                WIND6: begin
                    // release takes priority over a coincident tick
                    if (!key6Pressed) begin
                        r_cnt   <= '0;
                        r_state <= (r_angle != 4'sd0) ? STRIKE : IDLE;
                    end else if (w_tick && r_angle != MAX_POS) begin
                        r_angle <= r_angle + 4'sd1;
                    end
                end
                WIND4: begin
                    if (!key4Pressed) begin
                        r_cnt   <= '0;
                        r_state <= (r_angle != 4'sd0) ? STRIKE : IDLE;
                    end else if (w_tick && r_angle != MAX_NEG) begin
                        r_angle <= r_angle - 4'sd1;
                    end
                end
                STRIKE: begin
                    r_kick_pulse    <= 1'b1;
                    r_kick_dir      <= !r_angle[3];
                    r_kick_strength <= w_abs[2:0];
                    r_cnt           <= '0;
                    r_state         <= RECOVER;
                end
                RECOVER: begin
                    if (w_tick) begin
                        if (w_abs <= 4'd2) begin
                            r_angle <= '0;
                            r_cnt   <= '0;
                            r_cd    <= '0;
                            r_armed <= 1'b0;
                            r_state <= COOLDOWN;
                        end else if (r_angle[3]) begin
                            r_angle <= r_angle + 4'sd2;
                        end else begin
                            r_angle <= r_angle - 4'sd2;
                        end
                    end
                end
                COOLDOWN: begin
                    if (w_tick) begin
                        if (r_cd == CD_LAST) begin
                            r_state <= IDLE;
                        end else begin
                            r_cd <= r_cd + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign angle         = r_angle;
    assign kick_pulse    = r_kick_pulse;
    assign kick_dir      = r_kick_dir;
    assign kick_strength = r_kick_strength;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_rod_kick_scheduler.sv
// Scoreboard bench for rod_kick_scheduler: each key press is turned into expected busy edges,
// angle steps and kick events with their cycle stamps; a negedge monitor consumes them.
module tb_rod_kick_scheduler;

    localparam int TICK_DIV       = 20;
    localparam int MAX_STEP       = 7;
    localparam int COOLDOWN_TICKS = 10;

    logic              clk = 1'b0;
    logic              resetN;
    logic              turbo;
    logic              key6;
    logic              key4;
    logic signed [3:0] angle;
    logic              kick_pulse;
    logic              kick_dir;
    logic [2:0]        kick_strength;
    logic              busy;

    typedef struct {int cyc; int val;} ang_ev_t;
    typedef struct {int cyc; int dir; int str;} kick_ev_t;

    ang_ev_t  ang_q[$];
    kick_ev_t kick_q[$];
    int       rise_q[$];
    int       fall_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int prev_angle = 0;
    bit prev_busy  = 1'b0;
    bit prev_kick  = 1'b0;

    rod_kick_scheduler #(
        .TICK_DIV      (TICK_DIV),
        .MAX_STEP      (MAX_STEP),
        .COOLDOWN_TICKS(COOLDOWN_TICKS)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .turbo        (turbo),
        .key6Pressed  (key6),
        .key4Pressed  (key4),
        .angle        (angle),
        .kick_pulse   (kick_pulse),
        .kick_dir     (kick_dir),
        .kick_strength(kick_strength),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", n, 0);
    endtask

    // Reference: ticks land every lim clocks after entry; release wins over a coincident tick.
    task automatic kick_txn(input int key, input int d, input bit tb, input int other_at);
        int lim, s, p0, k, v, j, sgn;
        step();
        turbo = tb;
        step();
        p0  = cyc;
        lim = tb ? TICK_DIV / 10 : TICK_DIV;
        sgn = (key == 6) ? 1 : -1;
        s   = (d - 1) / lim;
        if (s > MAX_STEP) s = MAX_STEP;
        rise_q.push_back(p0 + 1);
        for (int i = 1; i <= s; i++) ang_q.push_back('{p0 + 1 + i * lim, sgn * i});
        if (s == 0) begin
            fall_q.push_back(p0 + d + 1);
        end else begin
            k = p0 + d + 2;
            kick_q.push_back('{k, (key == 6) ? 1 : 0, s});
            v = s;
            j = 0;
            while (v > 0) begin
                j++;
                v = (v >= 2) ? v - 2 : 0;
                ang_q.push_back('{k + j * lim, sgn * v});
            end
            fall_q.push_back(k + (j + COOLDOWN_TICKS) * lim);
        end
        if (key == 6) key6 = 1'b1;
        else key4 = 1'b1;
        for (int i = 1; i <= d; i++) begin
            step();
            if (i == other_at) begin
                if (key == 6) key4 = 1'b1;
                else key6 = 1'b1;
            end
        end
        key6 = 1'b0;
        key4 = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        ang_ev_t  ae;
        kick_ev_t ke;
        int       a;
        a = $signed(angle);
        if (mon_en) begin
            if (busy && !prev_busy) begin
                if (rise_q.size() == 0) check("busy_rise_unexpected", cyc, -1);
                else check("busy_rise_cycle", cyc, rise_q.pop_front());
            end
            if (!busy && prev_busy) begin
                if (fall_q.size() == 0) check("busy_fall_unexpected", cyc, -1);
                else check("busy_fall_cycle", cyc, fall_q.pop_front());
            end
            if (a != prev_angle) begin
                if (ang_q.size() == 0) begin
                    check("angle_change_unexpected", cyc, -1);
                end else begin
                    ae = ang_q.pop_front();
                    check("angle_step_cycle", cyc, ae.cyc);
                    check("angle_step_value", a, ae.val);
                end
            end
            if (kick_pulse) begin
                check("kick_width", int'(prev_kick), 0);
                if (kick_q.size() == 0) begin
                    check("kick_unexpected", cyc, -1);
                end else begin
                    ke = kick_q.pop_front();
                    check("kick_cycle", cyc, ke.cyc);
                    check("kick_dir", int'(kick_dir), ke.dir);
                    check("kick_strength", int'(kick_strength), ke.str);
                end
            end
        end
        prev_angle = a;
        prev_busy  = busy;
        prev_kick  = kick_pulse;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_angle"}, int'($signed(angle)), 0);
        check({tag, "_kick_pulse"}, int'(kick_pulse), 0);
        check({tag, "_kick_dir"}, int'(kick_dir), 0);
        check({tag, "_kick_strength"}, int'(kick_strength), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, key, d;
        bit tb;
        resetN = 1'b0;
        turbo  = 1'b0;
        key6   = 1'b0;
        key4   = 1'b0;
        #12;
        check_all_zero("reset");
        #11;
        resetN = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Normal kick, then the kick fields stay latched
        kick_txn(6, 65, 1'b0, 0);
        wait_idle();
        check("held_strength_normal", int'(kick_strength), 3);
        check("held_dir_normal", int'(kick_dir), 1);

        // Turbo saturation toward key4
        kick_txn(4, 200, 1'b1, 0);
        wait_idle();
        check("held_strength_sat", int'(kick_strength), 7);
        check("held_dir_sat", int'(kick_dir), 0);

        // Short tap
        kick_txn(6, 5, 1'b0, 0);
        wait_idle();

        // Simultaneous press has no owner
        step();
        key6 = 1'b1;
        key4 = 1'b1;
        repeat (30) step();
        check("conflict_busy", int'(busy), 0);
        check("conflict_angle", int'($signed(angle)), 0);
        key6 = 1'b0;
        key4 = 1'b0;
        repeat (2) step();

        // key4 joins while key6 owns the rod
        kick_txn(6, 65, 1'b0, 10);
        wait_idle();

        // Holding key6 through recovery and cooldown must not re-trigger
        kick_txn(6, 9, 1'b1, 0);
        repeat (3) step();
        key6 = 1'b1;
        wait_idle();
        repeat (40) step();
        check("no_repeat_busy", int'(busy), 0);
        key6 = 1'b0;
        kick_txn(6, 30, 1'b0, 0);
        wait_idle();

        // Reset in the middle of a key4 wind-up
        mon_en = 1'b0;
        step();
        turbo = 1'b0;
        key4  = 1'b1;
        n = 0;
        while ($signed(angle) != -4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("wind_to_minus4_timeout", n, 0);
        #3;
        resetN = 1'b0;
        #1;
        check_all_zero("midreset");
        key4 = 1'b0;
        @(negedge clk);
        #3;
        resetN = 1'b1;
        ang_q.delete();
        kick_q.delete();
        rise_q.delete();
        fall_q.delete();
        @(negedge clk);
        mon_en = 1'b1;
        kick_txn(4, 45, 1'b0, 0);
        wait_idle();

        // Randomised presses
        for (int t = 0; t < 16; t++) begin
            key = ($urandom_range(0, 1) == 1) ? 6 : 4;
            tb  = 1'($urandom_range(0, 1));
            d   = tb ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 170));
            repeat ($urandom_range(0, 4)) step();
            kick_txn(key, d, tb, 0);
            wait_idle();
        end

        repeat (5) step();
        check("left_rise", rise_q.size(), 0);
        check("left_fall", fall_q.size(), 0);
        check("left_angle", ang_q.size(), 0);
        check("left_kick", kick_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rod_kick_scheduler.md
Name: rod_kick_scheduler

Overview:
- Sequences one foosball rod's kick from the two rotation keys (key6 / key4). A held key winds the rod up in steps on a slow tick; releasing it fires a one-cycle kick whose strength equals the wind-up angle.
- The rod then recovers to neutral and sits out a cooldown.
- Arbitrates between the two keys: only one direction owns the rod at a time. Sits between the keypad decoder and the rod drawing/ball-collision logic.

Parameters:
- TICK_DIV, 2_500_000, clocks per rotation tick in normal mode (20 Hz at 50 MHz). Simulation uses 20.
- MAX_STEP, 7, maximum wind-up magnitude in steps. Range 1..7.
- COOLDOWN_TICKS, 10, ticks spent in COOLDOWN.

Ports:
- clk, in, 1, system clock 50 MHz.
- resetN, in, 1, asynchronous active-low reset.
- turbo, in, 1, tick period becomes TICK_DIV/10 (compile-time division).
- key6Pressed, in, 1, level, synchronous to clk.
- key4Pressed, in, 1, level, synchronous to clk.
- angle, out, 4 signed, rod rotation in steps, -MAX_STEP..+MAX_STEP. key6 winds positive, key4 winds negative.
- kick_pulse, out, 1, single-cycle kick strobe.
- kick_dir, out, 1, 1 = kick toward the key4 side (released from positive angle), 0 = toward the key6 side. Valid with kick_pulse, held afterwards.
- kick_strength, out, 3, |angle| at release. Valid with kick_pulse, held afterwards.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- Reset: asynchronous, applies immediately, including mid-operation.
  - state = IDLE, angle = 0, kick_pulse = 0, kick_dir = 0, kick_strength = 0, busy = 0.
  - Tick counter = 0, armed = 1.
- Tick generator:
  - limit = turbo ? TICK_DIV/10 : TICK_DIV.
  - Counter cleared in IDLE and on every state entry. Otherwise it increments each clock.
  - When counter >= limit-1, tick = 1 for that cycle and the counter returns to 0.
  - If turbo toggles mid-count with counter already >= the new limit-1, tick fires on the next cycle.
- armed flag:
  - Cleared on entering COOLDOWN.
  - Set in IDLE when both keys are low.
  - While armed = 0, IDLE ignores keys, so a held key never auto-repeats a kick.
- States:
  - IDLE:
    - angle = 0.
    - armed and key6 only -> WIND6 next cycle.
    - armed and key4 only -> WIND4 next cycle.
    - Both keys high -> stay IDLE (conflict, no owner).
  - WIND6:
    - On tick, angle += 1, saturating at +MAX_STEP.
    - key4 is ignored (rod locked to owner).
    - key6 low with angle != 0 -> STRIKE.
    - key6 low with angle == 0 -> IDLE, no kick (tap shorter than one tick).
  - WIND4: mirror of WIND6 with angle decrementing to -MAX_STEP.
  - STRIKE: exactly one cycle.
    - kick_pulse = 1, kick_strength = |angle|, kick_dir = (angle > 0).
    - Go to RECOVER.
  - RECOVER:
    - On tick, angle moves 2 toward 0 without overshoot (|angle| == 1 -> 0).
    - When angle reaches 0 -> COOLDOWN.
  - COOLDOWN:
    - Count COOLDOWN_TICKS ticks, keys ignored, then IDLE.
- Outputs are registered.
  - kick_pulse never lasts more than one cycle.
  - kick_pulse is 0 in every state but STRIKE.
  - angle changes only on a tick, or to 0 on reset.
- Key-release latency: STRIKE is entered on the first clock that samples the owner key low. kick_pulse is high on the following edge.

Test Plan (TICK_DIV = 20, MAX_STEP = 7, COOLDOWN_TICKS = 10):
- Normal kick: hold key6 for 65 clocks, then release.
  - angle steps 0,1,2,3.
  - One cycle of kick_pulse = 1 with kick_strength = 3, kick_dir = 1.
  - angle goes 3 -> 1 -> 0 on successive ticks, then busy is held for 10 ticks, then IDLE.
- Saturation with turbo: turbo = 1, hold key4 for 200 clocks (100 ticks).
  - angle stops at -7.
  - On release: kick_strength = 7, kick_dir = 0.
  - Recovery goes -7 -5 -3 -1 0.
- Short tap: key6 high for 5 clocks, then low.
  - No kick_pulse, angle stays 0, back to IDLE, busy low within 2 cycles of release.
- Arbitration:
  - key6 and key4 rising on the same cycle -> stays IDLE, busy = 0.
  - key6 first, key4 pressed later -> angle still increments positive; key4 is ignored until key6 releases.
- No auto-repeat: keep key6 held throughout kick and cooldown.
  - No new WIND6 until key6 drops low in IDLE.
  - The press after that starts a new wind-up.
- Reset mid-operation: assert resetN = 0 during WIND4 at angle -4.
  - All outputs are 0 and busy = 0 immediately.
  - After release of reset with keys low, the next key4 press winds from 0.
